// File: rtl/io_pkg.sv
// Shared constants for the CPU I/O responder: port addresses, STATUS bit
// positions, CTRL bit positions and the STATUS word packer.
package io_pkg;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_RXV   = 2;
  localparam int ST_DROP  = 3;
  localparam int ST_UNDER = 4;

  localparam int CT_CLRDROP  = 0;
  localparam int CT_CLRUNDER = 1;
  localparam int CT_FLUSH    = 2;

  // The upper three STATUS bits always read as zero.
  function automatic logic [7:0] pack_status(
    input logic full,
    input logic empty,
    input logic rx_valid,
    input logic tx_drop,
    input logic rx_underrun
  );
    logic [7:0] s;
    s           = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_RXV]   = rx_valid;
    s[ST_DROP]  = tx_drop;
    s[ST_UNDER] = rx_underrun;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Transmit FIFO. A push into a full FIFO is ignored here; the caller flags
// the drop. Flush empties the FIFO and overrides any push or pop in that cycle.
module io_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: the storage array has no reset; the pointers and count alone define
  // which entries are valid, so the stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // NOTE: state is assigned with <= so every register sees pre-edge values,
  // which is what makes a same-edge push and pop see the old count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pointers are AW bits wide, so the increments wrap modulo DEPTH.
  assign dout = mem[rptr];

endmodule

// File: rtl/io_port_responder.sv
// CPU-side I/O responder: TX FIFO toward an external consumer, a one-entry RX
// holding register from an external producer, sticky error flags, and read mux.
module io_port_responder
  import io_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_we,
  input  logic       io_re,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_wd,
  output logic [7:0] io_rd,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready
);

  logic [AW:0] tx_count;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_write;
  logic        ctrl_write;
  logic        tx_pop;
  logic        tx_flush;
  logic        rx_read;
  logic        rx_capture;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_drop;
  logic        rx_underrun;

  assign tx_write   = io_we && (io_addr == ADDR_TXDATA);
  assign ctrl_write = io_we && (io_addr == ADDR_CTRL);
  assign tx_flush   = ctrl_write && io_wd[CT_FLUSH];
  assign tx_pop     = out_valid && out_ready;
  assign rx_read    = io_re && (io_addr == ADDR_RXDATA);
  assign in_ready   = !rx_valid;
  assign rx_capture = in_valid && in_ready;
  assign out_valid  = (tx_count != '0);

  io_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_write),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (io_wd),
    .dout  (out_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Capture and read-clear never coincide: capture needs rx_valid=0, clear needs 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
    end else if (rx_capture) begin
      rx_valid <= 1'b1;
    end else if (rx_read) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_capture) rx_data <= in_data;
  end

  // Set and clear of one flag need different addresses, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_drop     <= 1'b0;
      rx_underrun <= 1'b0;
    end else begin
      if (tx_write && tx_full)
        tx_drop <= 1'b1;
      else if (ctrl_write && io_wd[CT_CLRDROP])
        tx_drop <= 1'b0;

      if (rx_read && !rx_valid)
        rx_underrun <= 1'b1;
      else if (ctrl_write && io_wd[CT_CLRUNDER])
        rx_underrun <= 1'b0;
    end
  end

  // NOTE: io_rd gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    io_rd = '0;
    case (io_addr)
      ADDR_RXDATA: io_rd = rx_valid ? rx_data : 8'h00;
      ADDR_STATUS: io_rd = pack_status(tx_full, tx_empty, rx_valid, tx_drop, rx_underrun);
      default:     io_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed self-checking bench for io_port_responder (DEPTH=4).
module tb_io_port_responder;

  logic       clk;
  logic       reset;
  logic       io_we;
  logic       io_re;
  logic [1:0] io_addr;
  logic [7:0] io_wd;
  logic [7:0] io_rd;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  int checks   = 0;
  int failures = 0;

  io_port_responder #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_addr   (io_addr),
    .io_wd     (io_wd),
    .io_rd     (io_rd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    io_we   = 1'b1;
    io_addr = a;
    io_wd   = d;
    tick();
    io_we   = 1'b0;
    io_addr = 2'd0;
    io_wd   = 8'h00;
  endtask

  task automatic check_status(input string tag, input logic [7:0] expected);
    io_addr = 2'd2;
    #1;
    check(tag, io_rd, expected);
    io_addr = 2'd0;
  endtask

  initial begin
    reset = 1'b1; io_we = 1'b0; io_re = 1'b0; io_addr = 2'd0; io_wd = 8'h00;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("reset_out_valid", {7'd0, out_valid}, 8'h00);
    check("reset_in_ready",  {7'd0, in_ready},  8'h01);
    tick(); tick();
    reset = 1'b0;
    check_status("reset_status", 8'h02);
    io_addr = 2'd0; #1;
    check("reset_rd_addr0", io_rd, 8'h00);
    io_addr = 2'd3; #1;
    check("reset_rd_addr3", io_rd, 8'h00);
    io_addr = 2'd0;

    // Fill to full, then overflow.
    cpu_write(2'd0, 8'h11);
    cpu_write(2'd0, 8'h22);
    cpu_write(2'd0, 8'h33);
    cpu_write(2'd0, 8'h44);
    check_status("full_status", 8'h01);
    check("full_head", out_data, 8'h11);
    cpu_write(2'd0, 8'h55);
    check_status("overflow_status", 8'h09);

    // Drain in order.
    out_ready = 1'b1; #1;
    check("drain0", out_data, 8'h11);
    tick(); check("drain1", out_data, 8'h22);
    tick(); check("drain2", out_data, 8'h33);
    tick(); check("drain3", out_data, 8'h44);
    tick(); check("drained_valid", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
    check_status("drained_status", 8'h0A);
    cpu_write(2'd3, 8'h01);
    check_status("clrdrop_status", 8'h02);

    // Simultaneous push/pop at count=2.
    cpu_write(2'd0, 8'hA1);
    cpu_write(2'd0, 8'hA2);
    io_we = 1'b1; io_addr = 2'd0; io_wd = 8'h66; out_ready = 1'b1;
    tick();
    io_we = 1'b0; out_ready = 1'b0;
    check_status("pushpop2_status", 8'h00);
    check("pushpop2_head", out_data, 8'hA2);

    // Simultaneous push/pop at count=4: push dropped.
    cpu_write(2'd0, 8'hB3);
    cpu_write(2'd0, 8'hB4);
    check_status("pushpop4_pre", 8'h01);
    io_we = 1'b1; io_addr = 2'd0; io_wd = 8'h77; out_ready = 1'b1;
    tick();
    io_we = 1'b0; out_ready = 1'b0;
    check_status("pushpop4_status", 8'h08);
    out_ready = 1'b1; #1;
    check("pp_order0", out_data, 8'h66);
    tick(); check("pp_order1", out_data, 8'hB3);
    tick(); check("pp_order2", out_data, 8'hB4);
    tick(); check("pp_empty", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
    cpu_write(2'd3, 8'h01);
    check_status("clrdrop2_status", 8'h02);

    // RX capture, read, back-to-back second value.
    in_valid = 1'b1; in_data = 8'hA5; #1;
    check("rx_ready_pre", {7'd0, in_ready}, 8'h01);
    tick();
    in_data = 8'h5A;
    check("rx_ready_after", {7'd0, in_ready}, 8'h00);
    check_status("rx_status", 8'h06);
    tick();
    io_re = 1'b1; io_addr = 2'd1; #1;
    check("rx_read_data", io_rd, 8'hA5);
    tick();
    io_re = 1'b0;
    check("rx_cleared_ready", {7'd0, in_ready}, 8'h01);
    check("rx_cleared_rd", io_rd, 8'h00);
    tick();
    in_valid = 1'b0;
    io_addr = 2'd1; #1;
    check("rx_second_data", io_rd, 8'h5A);
    check("rx_second_ready", {7'd0, in_ready}, 8'h00);
    io_re = 1'b1;
    tick();
    io_re = 1'b0;
    check_status("rx_drained_status", 8'h02);

    // Underrun.
    io_re = 1'b1; io_addr = 2'd1; #1;
    check("underrun_rd", io_rd, 8'h00);
    tick();
    io_re = 1'b0;
    check_status("underrun_status", 8'h12);
    cpu_write(2'd3, 8'h02);
    check_status("clrunder_status", 8'h02);

    // Writes to RXDATA/STATUS are ignored; reads of non-RX have no effect.
    cpu_write(2'd1, 8'hFF);
    cpu_write(2'd2, 8'hFF);
    io_re = 1'b1; io_addr = 2'd2; tick(); io_re = 1'b0;
    check_status("ignored_status", 8'h02);

    // Flush with a concurrent pop request.
    cpu_write(2'd0, 8'hC1);
    cpu_write(2'd0, 8'hC2);
    cpu_write(2'd0, 8'hC3);
    check_status("preflush_status", 8'h00);
    out_ready = 1'b1;
    cpu_write(2'd3, 8'h04);
    check("flush_valid", {7'd0, out_valid}, 8'h00);
    check_status("flush_status", 8'h02);
    tick();
    check("flush_valid_later", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;

    // No bypass: pushed data appears only after the push edge.
    io_we = 1'b1; io_addr = 2'd0; io_wd = 8'hD1; #1;
    check("nobypass_pre", {7'd0, out_valid}, 8'h00);
    tick();
    io_we = 1'b0;
    check("nobypass_valid", {7'd0, out_valid}, 8'h01);
    check("nobypass_data", out_data, 8'hD1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("nobypass_popped", {7'd0, out_valid}, 8'h00);

    // Asynchronous reset mid-drain and mid-RX.
    cpu_write(2'd0, 8'hE1);
    cpu_write(2'd0, 8'hE2);
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    out_ready = 1'b1;
    check("prereset_rxv", {7'd0, in_ready}, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", {7'd0, out_valid}, 8'h00);
    check("areset_in_ready",  {7'd0, in_ready},  8'h01);
    check_status("areset_status", 8'h02);
    tick();
    check("hold_out_valid", {7'd0, out_valid}, 8'h00);
    check("hold_in_ready",  {7'd0, in_ready},  8'h01);
    check_status("hold_status", 8'h02);
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_status("postreset_status", 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
